// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the memory access controller.
package mem_access_ctrl_pkg;

  localparam int unsigned WordBits = 32;
  localparam int unsigned ByteBits = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    StIdle,
    StRdIssue,
    StRdWait,
    StWrIssue,
    StResp
  } state_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response and word-RAM bundle; slave is the controller side, master the requester/RAM side.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        ram_en;
  logic        ram_we;
  logic        ram_rst;
  logic [31:0] ram_addr;
  logic [31:0] ram_di;
  logic [31:0] ram_dout;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready, ram_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err, ram_en, ram_we, ram_rst, ram_addr, ram_di
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready, ram_dout,
    output req_ready, resp_valid, resp_rdata, resp_err, ram_en, ram_we, ram_rst, ram_addr, ram_di
  );
endinterface

// File: rtl/mem_lane_fmt.sv
// Combinational store-merge and load extract/extend for byte and halfword accesses.
module mem_lane_fmt
  import mem_access_ctrl_pkg::*;
(
  input  size_e       i_size,
  input  logic        i_signed,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_merged,
  output logic [31:0] o_load
);

  logic [ByteBits-1:0]   w_byte;
  logic [2*ByteBits-1:0] w_half;

  always_comb begin
    o_merged = i_rdata;
    o_load   = i_rdata;
    w_byte   = i_rdata[{i_lane, 3'b000} +: ByteBits];
    w_half   = i_rdata[{i_lane[1], 4'b0000} +: 2*ByteBits];
    case (i_size)
      SZ_BYTE: begin
        o_merged[{i_lane, 3'b000} +: ByteBits] = i_wdata[ByteBits-1:0];
        o_load = {{(WordBits-ByteBits){i_signed & w_byte[ByteBits-1]}}, w_byte};
      end
      SZ_HALF: begin
        o_merged[{i_lane[1], 4'b0000} +: 2*ByteBits] = i_wdata[2*ByteBits-1:0];
        o_load = {{(WordBits-2*ByteBits){i_signed & w_half[2*ByteBits-1]}}, w_half};
      end
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller in front of a word RAM with read-modify-write for sub-word stores.
// Sub-word accesses exist only when MEM_ACCESS_SUBWORD_EN is defined; otherwise byte/half are errors.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 131072
) (
  input logic              clk,
  input logic              rst,
  mem_access_ctrl_if.slave bus
);

  localparam logic [33:0] MemBytes = 34'(MEM_WORDS) << 2;

  state_e      r_state;
  logic        r_we;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;
  logic        r_ram_en;
  logic        r_ram_we;
  logic [31:0] r_ram_addr;
  logic [31:0] r_ram_di;

  logic        w_err;
  logic        w_word_store;
  logic [31:0] w_merged;
  logic [31:0] w_load;

`ifdef MEM_ACCESS_SUBWORD_EN
  size_e       r_size;
  logic        r_signed;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;

  mem_lane_fmt u_lane_fmt (
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_lane   (r_lane),
    .i_wdata  (r_wdata),
    .i_rdata  (bus.ram_dout),
    .o_merged (w_merged),
    .o_load   (w_load)
  );
`else
  assign w_merged = bus.ram_dout;
  assign w_load   = bus.ram_dout;
`endif

  always_comb begin
    w_err = 1'b0;
    case (bus.req_size)
`ifdef MEM_ACCESS_SUBWORD_EN
      SZ_BYTE: w_err = 1'b0;
      SZ_HALF: w_err = bus.req_addr[0];
`endif
      SZ_WORD: w_err = |bus.req_addr[1:0];
      default: w_err = 1'b1;
    endcase
    if ({2'b00, bus.req_addr} >= MemBytes) w_err = 1'b1;
  end

  assign w_word_store = bus.req_we & (bus.req_size == SZ_WORD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_we         <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_ram_en     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_di     <= '0;
`ifdef MEM_ACCESS_SUBWORD_EN
      r_size       <= SZ_WORD;
      r_signed     <= 1'b0;
      r_lane       <= '0;
      r_wdata      <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.req_valid && r_req_ready) begin
            r_we        <= bus.req_we;
            r_req_ready <= 1'b0;
            r_ram_addr  <= {bus.req_addr[31:2], 2'b00};
`ifdef MEM_ACCESS_SUBWORD_EN
            r_size      <= size_e'(bus.req_size);
            r_signed    <= bus.req_signed;
            r_lane      <= bus.req_addr[1:0];
            r_wdata     <= bus.req_wdata;
`endif
            if (w_err) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
              r_state      <= StResp;
            end else if (w_word_store) begin
              r_ram_en <= 1'b1;
              r_ram_we <= 1'b1;
              r_ram_di <= bus.req_wdata;
              r_state  <= StWrIssue;
            end else begin
              r_ram_en <= 1'b1;
              r_ram_we <= 1'b0;
              r_state  <= StRdIssue;
            end
          end
        end
        StRdIssue: begin
          r_ram_en <= 1'b0;
          r_state  <= StRdWait;
        end
        StRdWait: begin
          if (!r_we) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= w_load;
            r_state      <= StResp;
          end else begin
            // Sub-word store: write back the read word with only the addressed lanes replaced.
            r_ram_en <= 1'b1;
            r_ram_we <= 1'b1;
            r_ram_di <= w_merged;
            r_state  <= StWrIssue;
          end
        end
        StWrIssue: begin
          r_ram_en     <= 1'b0;
          r_ram_we     <= 1'b0;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
          r_state      <= StResp;
        end
        StResp: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_req_ready  <= 1'b1;
            r_state      <= StIdle;
          end
        end
        default: begin
          r_ram_en    <= 1'b0;
          r_ram_we    <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= StIdle;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.ram_en     = r_ram_en;
  assign bus.ram_we     = r_ram_we;
  assign bus.ram_rst    = 1'b0;
  assign bus.ram_addr   = r_ram_addr;
  assign bus.ram_di     = r_ram_di;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a byte-array memory model; honours MEM_ACCESS_SUBWORD_EN.
module tb_mem_access_ctrl;

  localparam int unsigned MemWords = 256;
  localparam int unsigned MemBytes = MemWords * 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(
    .MEM_WORDS (MemWords)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Word RAM with one-cycle synchronous read.
  logic [31:0] ram [MemWords];
  int unsigned n_rd = 0;
  int unsigned n_wr = 0;
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) begin
        ram[bus.ram_addr[31:2] % MemWords] <= bus.ram_di;
        n_wr <= n_wr + 1;
      end else begin
        bus.ram_dout <= ram[bus.ram_addr[31:2] % MemWords];
        n_rd <= n_rd + 1;
      end
    end
  end

  logic [7:0]  mdl [MemBytes];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference behaviour from the access rules: returns expected response and updates model memory.
  task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic err, output logic [31:0] data,
                       output int lat, output int nrd, output int nwr);
    int nb;
    nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err  = (size == 2'd3) || ((addr % nb) != 0) || (longint'(addr) >= longint'(MemBytes));
`ifndef MEM_ACCESS_SUBWORD_EN
    if (size != 2'd2) err = 1'b1;
`endif
    data = '0;
    if (err) begin
      lat = 1; nrd = 0; nwr = 0;
    end else if (we) begin
      for (int i = 0; i < nb; i++) mdl[addr + i] = wdata[8*i +: 8];
      lat = (nb == 4) ? 2 : 4;
      nrd = (nb == 4) ? 0 : 1;
      nwr = 1;
    end else begin
      for (int i = 0; i < nb; i++) data = data | (32'(mdl[addr + i]) << (8 * i));
      if (sgn && nb < 4 && data[8*nb-1]) data = data | ~((32'd1 << (8 * nb)) - 32'd1);
      lat = 3; nrd = 1; nwr = 0;
    end
  endtask

  task automatic do_txn(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                        output logic [31:0] got);
    logic        e_err;
    logic [31:0] e_data;
    int          e_lat, e_rd, e_wr, lat;
    int unsigned rd0, wr0;
    model(we, size, sgn, addr, wdata, e_err, e_data, e_lat, e_rd, e_wr);
    @(negedge clk);
    check_eq("req_ready_idle", 32'(bus.req_ready), 32'd1);
    rd0 = n_rd;
    wr0 = n_wr;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq("latency", 32'(lat), 32'(e_lat));
    check_eq("resp_err", 32'(bus.resp_err), 32'(e_err));
    check_eq("resp_rdata", bus.resp_rdata, e_data);
    got = bus.resp_rdata;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check_eq("hold_valid", 32'(bus.resp_valid), 32'd1);
      check_eq("hold_rdata", bus.resp_rdata, e_data);
      check_eq("hold_err", 32'(bus.resp_err), 32'(e_err));
      check_eq("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check_eq("resp_valid_drop", 32'(bus.resp_valid), 32'd0);
    check_eq("req_ready_back", 32'(bus.req_ready), 32'd1);
    check_eq("ram_reads", n_rd - rd0, 32'(e_rd));
    check_eq("ram_writes", n_wr - wr0, 32'(e_wr));
    if (e_rd + e_wr > 0) check_eq("ram_addr", bus.ram_addr, {addr[31:2], 2'b00});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] a, d;
    logic [1:0]  sz;
    int unsigned wr0;
    for (int i = 0; i < int'(MemBytes); i++) mdl[i] = 8'h00;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_signed = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_eq("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check_eq("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check_eq("rst_ram_en", 32'(bus.ram_en), 32'd0);
    check_eq("rst_ram_we", 32'(bus.ram_we), 32'd0);
    check_eq("rst_ram_addr", bus.ram_addr, 32'd0);
    check_eq("rst_ram_di", bus.ram_di, 32'd0);
    check_eq("rst_ram_rst", 32'(bus.ram_rst), 32'd0);
    rst = 1'b0;

    // Fill the first 16 words so later loads see known data.
    for (int w = 0; w < 16; w++) do_txn(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 0, got);

    do_txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, got);
    check_eq("word4_ram", ram[4], 32'hDEADBEEF);
    do_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, got);
    check_eq("beef_load", got, 32'hDEADBEEF);

    do_txn(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 0, got);
    do_txn(1'b1, 2'd0, 1'b0, 32'h22, 32'h000000AA, 0, got);
    do_txn(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, got);
`ifdef MEM_ACCESS_SUBWORD_EN
    check_eq("merge_aa", got, 32'h11AA3344);
`else
    check_eq("no_merge", got, 32'h11223344);
`endif

    do_txn(1'b1, 2'd2, 1'b0, 32'h30, 32'h0000F080, 0, got);
    do_txn(1'b0, 2'd0, 1'b1, 32'h30, 32'h0, 0, got);
`ifdef MEM_ACCESS_SUBWORD_EN
    check_eq("sbyte_load", got, 32'hFFFFFF80);
`endif
    do_txn(1'b0, 2'd1, 1'b0, 32'h30, 32'h0, 0, got);
`ifdef MEM_ACCESS_SUBWORD_EN
    check_eq("uhalf_load", got, 32'h0000F080);
`endif

    do_txn(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 0, got);
    do_txn(1'b0, 2'd3, 1'b0, 32'h8, 32'h0, 0, got);
    do_txn(1'b0, 2'd2, 1'b0, 32'(MemBytes), 32'h0, 0, got);
    do_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, got);

    // Reset in RD_WAIT must drop any pending write.
    do_txn(1'b1, 2'd2, 1'b0, 32'h24, 32'h55667788, 0, got);
    @(negedge clk);
    wr0 = n_wr;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0; bus.req_signed = 1'b0;
    bus.req_addr = 32'h25; bus.req_wdata = 32'h11;
`ifndef MEM_ACCESS_SUBWORD_EN
    bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_addr = 32'h24;
`endif
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rmw_rst_req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("rmw_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_eq("rmw_rst_ram_en", 32'(bus.ram_en), 32'd0);
    repeat (2) @(negedge clk);
    check_eq("rmw_rst_no_write", n_wr - wr0, 32'd0);
    do_txn(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 0, got);
    check_eq("rmw_rst_word", got, 32'h55667788);

    for (int n = 0; n < 150; n++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) sz = 2'd2;
      case ($urandom_range(0, 9))
        0:       a = MemBytes + $urandom_range(0, 255);
        1:       a = $urandom;
        default: a = 32'($urandom_range(0, 63));
      endcase
      d = $urandom;
      do_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, d,
             int'($urandom_range(0, 3)), got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
